// File: rtl/layer_output_packer_pkg.sv
// Shared constants for the output stage and the state encoding of the packer.
//   NN_OUT_NUM : neurons in the final dense layer (elements per packed vector)
//   NN_DATA_W  : bits per element (signed fixed-point)
//   pack_state_e : COLLECT gathers a frame, DISCARD drops beats until the next i_last
package layer_output_packer_pkg;

    localparam int NN_OUT_NUM = 10;
    localparam int NN_DATA_W  = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        DISCARD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/layer_output_packer.sv
// Collects serially produced neuron outputs (one element per beat) into one packed
// vector and hands it to the classifier with a one-cycle valid pulse. Frame alignment
// is checked against the i_last marker; misaligned frames are dropped and flagged.
//
// Ports
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_data         : element value, inputWidth bits
//   i_valid        : element beat qualifier
//   i_last         : final element of a frame (only meaningful with i_valid)
//   i_flush        : synchronous abort of a partial frame, wins over i_valid
//   o_data         : packed vector, element k at [k*inputWidth +: inputWidth]
//   o_data_valid   : one-cycle pulse, o_data holds a newly completed vector
//   o_frame_err    : one-cycle pulse, a framing error was detected
//   o_frame_cnt    : number of emitted vectors, wraps 0xFFFF -> 0
//   o_dbg_state    : current FSM state, for observation only
//
// Handshake: a beat is transferred on every rising edge where i_valid=1 and i_flush=0.
// There is no ready; the source cannot be stalled, so every beat is consumed in the
// cycle it is presented. Outputs are valid-only pulses with no downstream ready either.
module layer_output_packer
    import layer_output_packer_pkg::*;
#(
    parameter int numInput   = NN_OUT_NUM,
    parameter int inputWidth = NN_DATA_W
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [inputWidth-1:0]          i_data,
    input  logic                           i_valid,
    input  logic                           i_last,
    input  logic                           i_flush,
    output logic [numInput*inputWidth-1:0] o_data,
    output logic                           o_data_valid,
    output logic                           o_frame_err,
    output logic [15:0]                    o_frame_cnt,
    output pack_state_e                    o_dbg_state
);

    localparam int               CNT_W    = $clog2(numInput);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(numInput - 1);
    localparam int               BUF_W    = (numInput - 1) * inputWidth;

    pack_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only slices 0..N-2 are buffered; the final element goes straight from
    // i_data into o_data on the emitting beat.
    logic [BUF_W-1:0] buf_q;
    logic             wr_en;
    logic             emit;
    logic             err;

    // Next-state / control decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        emit    = 1'b0;
        err     = 1'b0;
        if (i_flush) begin
            state_d = COLLECT;
            cnt_d   = '0;
        end else if (i_valid) begin
            case (state_q)
                COLLECT: begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (i_last) begin
                            emit = 1'b1;
                        end else begin
                            // Missing last: the rest of this frame is still coming.
                            err     = 1'b1;
                            state_d = DISCARD;
                        end
                    end else if (i_last) begin
                        // Early last: the frame already ended, resync immediately.
                        err   = 1'b1;
                        cnt_d = '0;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DISCARD: begin
                    if (i_last) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slice writes decode the counter against constant indices, so every
    // part-select offset is a compile-time constant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_q <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < numInput - 1; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    buf_q[k*inputWidth +: inputWidth] <= i_data;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_frame_cnt  <= '0;
        end else begin
            o_data_valid <= emit;
            o_frame_err  <= err;
            if (emit) begin
                o_data      <= {i_data, buf_q};
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_layer_output_packer.sv
module tb_layer_output_packer;
    import layer_output_packer_pkg::*;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int VW = N * W;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst_n;
    logic [W-1:0]  i_data;
    logic          i_valid;
    logic          i_last;
    logic          i_flush;
    logic [VW-1:0] o_data;
    logic          o_data_valid;
    logic          o_frame_err;
    logic [15:0]   o_frame_cnt;
    pack_state_e   o_dbg_state;

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    layer_output_packer #(.numInput(N), .inputWidth(W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_last       (i_last),
        .i_flush      (i_flush),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_frame_err  (o_frame_err),
        .o_frame_cnt  (o_frame_cnt),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Each expected output event: a vector emission or an error pulse, with the
    // cycle it must appear in and the o_data / o_frame_cnt it must show.
    typedef struct {
        logic          is_err;
        logic [VW-1:0] data;
        logic [15:0]   cnt;
        int            cyc;
    } ev_t;

    ev_t           exp_q[$];
    ev_t           ev;
    logic [VW-1:0] model_vec = '0;
    logic [15:0]   model_cnt = '0;
    int            errors = 0;
    int            checks = 0;

    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1) begin
            if (o_data_valid === 1'b1 && o_frame_err === 1'b1) begin
                errors++;
                $display("FAIL both_pulses: valid=%b err=%b at cycle %0d, required not both", o_data_valid, o_frame_err, cyc);
            end
            if (o_data_valid === 1'b1 || o_frame_err === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%b err=%b at cycle %0d, required no pulse", o_data_valid, o_frame_err, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (o_frame_err !== ev.is_err || o_data_valid !== !ev.is_err) begin
                        errors++;
                        $display("FAIL pulse_kind: valid=%b err=%b, required err=%b", o_data_valid, o_frame_err, ev.is_err);
                    end
                    if (cyc != ev.cyc) begin
                        errors++;
                        $display("FAIL pulse_cycle: got %0d required %0d", cyc, ev.cyc);
                    end
                    if (o_data !== ev.data) begin
                        errors++;
                        $display("FAIL pulse_data: got %h required %h", o_data, ev.data);
                    end
                    if (o_frame_cnt !== ev.cnt) begin
                        errors++;
                        $display("FAIL pulse_frame_cnt: got %h required %h", o_frame_cnt, ev.cnt);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [W-1:0] d, input logic last, input logic flush, output int c);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = last;
        i_flush = flush;
        @(posedge i_clk);
        #1;
        c       = cyc;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_flush = 1'b0;
        i_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
    endtask

    // A well-formed frame: element k is vals[k]; the vector emits one cycle
    // after the last beat and bumps the frame count.
    task automatic send_good(input logic [W-1:0] vals[N], input bit gaps);
        int c;
        logic [VW-1:0] vec;
        for (int k = 0; k < N; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_beat(vals[k], (k == N - 1), 1'b0, c);
            vec[k*W +: W] = vals[k];
        end
        model_cnt = model_cnt + 16'd1;
        model_vec = vec;
        exp_q.push_back('{1'b0, vec, model_cnt, c});
    endtask

    // Frame that ends after len < N beats: one error pulse, nothing emitted.
    task automatic send_short(input int len, input bit gaps);
        int c;
        for (int k = 0; k < len; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_beat(W'($urandom), (k == len - 1), 1'b0, c);
        end
        exp_q.push_back('{1'b1, model_vec, model_cnt, c});
    endtask

    // N beats without a last (error on the Nth), junk beats, then a terminating
    // beat with last; none of the tail beats produce anything.
    task automatic send_overlong(input int junk, input bit gaps);
        int c;
        for (int k = 0; k < N; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_beat(W'($urandom), 1'b0, 1'b0, c);
        end
        exp_q.push_back('{1'b1, model_vec, model_cnt, c});
        for (int k = 0; k < junk; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_beat(W'($urandom), 1'b0, 1'b0, c);
        end
        drive_beat(W'($urandom), 1'b1, 1'b0, c);
    endtask

    // Partial frame of p beats aborted by a flush cycle carrying a beat.
    task automatic send_flushed(input int p, input bit gaps);
        int c;
        for (int k = 0; k < p; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_beat(W'($urandom), 1'b0, 1'b0, c);
        end
        drive_beat(W'($urandom), 1'($urandom_range(0, 1)), 1'b1, c);
    endtask

    task automatic rand_vals(output logic [W-1:0] vals[N]);
        for (int k = 0; k < N; k++) vals[k] = W'($urandom);
    endtask

    task automatic check_drained(input string name);
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_flush = 1'b0;
        i_data  = '0;
        idle(2);
        @(negedge i_clk);
        checks++;
        if (o_data !== '0 || o_data_valid !== 1'b0 || o_frame_err !== 1'b0 ||
            o_frame_cnt !== 16'd0 || o_dbg_state !== COLLECT) begin
            errors++;
            $display("FAIL reset_outputs: data=%h v=%b e=%b cnt=%h st=%b, required all zero", o_data, o_data_valid, o_frame_err, o_frame_cnt, o_dbg_state);
        end
        i_rst_n = 1'b1;
        idle(2);
        check_drained("reset_release");
    endtask

    task automatic test_single_frame();
        logic [W-1:0] vals[N];
        for (int k = 0; k < N; k++) vals[k] = W'(k + 1);
        send_good(vals, 1'b0);
        check_drained("single");
        checks++;
        if (o_data[15:0] !== 16'h0001 || o_data[159:144] !== 16'h000A || o_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_slices: e0=%h e9=%h cnt=%h, required 0001 000a 0001", o_data[15:0], o_data[159:144], o_frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals[N];
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) vals[k] = W'(k + 1 + 16 * f);
            send_good(vals, 1'b0);
        end
        check_drained("back_to_back");
        checks++;
        if (o_frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL b2b_frame_cnt: got %h required 0004", o_frame_cnt);
        end
    endtask

    task automatic test_early_last();
        logic [W-1:0] vals[N];
        send_short(4, 1'b0);
        rand_vals(vals);
        send_good(vals, 1'b0);
        check_drained("early_last");
    endtask

    task automatic test_missing_last();
        logic [W-1:0] vals[N];
        int c;
        for (int k = 0; k < N; k++) drive_beat(W'($urandom), 1'b0, 1'b0, c);
        exp_q.push_back('{1'b1, model_vec, model_cnt, c});
        @(negedge i_clk);
        checks++;
        if (o_dbg_state !== DISCARD) begin
            errors++;
            $display("FAIL missing_last_state: got %b required DISCARD", o_dbg_state);
        end
        for (int k = 0; k < 3; k++) drive_beat(W'($urandom), 1'b0, 1'b0, c);
        drive_beat(W'($urandom), 1'b1, 1'b0, c);
        rand_vals(vals);
        send_good(vals, 1'b0);
        check_drained("missing_last");
    endtask

    task automatic test_flush();
        logic [W-1:0] vals[N];
        send_flushed(6, 1'b0);
        rand_vals(vals);
        send_good(vals, 1'b0);
        check_drained("flush");
    endtask

    task automatic test_reset_and_wrap();
        logic [W-1:0] vals[N];
        int c;
        for (int k = 0; k < 4; k++) drive_beat(W'($urandom), 1'b0, 1'b0, c);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_data !== '0 || o_data_valid !== 1'b0 || o_frame_err !== 1'b0 ||
            o_frame_cnt !== 16'd0 || o_dbg_state !== COLLECT) begin
            errors++;
            $display("FAIL midframe_reset: data=%h v=%b e=%b cnt=%h st=%b, required all zero", o_data, o_data_valid, o_frame_err, o_frame_cnt, o_dbg_state);
        end
        model_vec = '0;
        model_cnt = '0;
        exp_q.delete();
        idle(2);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(2);
        rand_vals(vals);
        send_good(vals, 1'b0);
        check_drained("after_reset");
        // Preload the frame count just below the wrap point.
        @(negedge i_clk);
        force dut.o_frame_cnt = 16'hFFFE;
        #1;
        release dut.o_frame_cnt;
        model_cnt = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            rand_vals(vals);
            send_good(vals, 1'b0);
        end
        check_drained("wrap");
        checks++;
        if (o_frame_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_frame_cnt: got %h required 0000", o_frame_cnt);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] vals[N];
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    rand_vals(vals);
                    send_good(vals, 1'($urandom_range(0, 1)));
                end
                3: send_short($urandom_range(1, N - 1), 1'($urandom_range(0, 1)));
                4: send_overlong($urandom_range(0, 4), 1'($urandom_range(0, 1)));
                default: send_flushed($urandom_range(0, N - 1), 1'($urandom_range(0, 1)));
            endcase
        end
        check_drained("random");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_early_last();
        test_missing_last();
        test_flush();
        test_random();
        test_reset_and_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
